// File: rtl/popcount_pkg.sv
// -----------------------------------------------------------------------------
// popcount_pkg
// Shared definitions for the streaming population counter:
//   - state_t : control states of the word-at-a-time FSM
//   - clog2   : ceiling log2, usable in constant expressions
//   - cnt_w   : width needed to hold a popcount of a WIDTH-bit word
//   - nchunk  : number of CHUNK-bit beats that make up one word
// -----------------------------------------------------------------------------
package popcount_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Smallest r with 2**r >= value (0 for value <= 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int cnt_w(input int width);
    return clog2(width + 1);
  endfunction

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/popcount_chunk.sv
// -----------------------------------------------------------------------------
// popcount_chunk
// Purely combinational population count of one CHUNK-bit slice.
// Ports:
//   i_bits : CHUNK-bit slice to count
//   o_cnt  : number of set bits, $clog2(CHUNK+1) wide
// -----------------------------------------------------------------------------
module popcount_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0]             i_bits,
  output logic [$clog2(CHUNK+1)-1:0]   o_cnt
);

  localparam int CC_W = $clog2(CHUNK + 1);

  always_comb begin
    o_cnt = '0;
    for (int i = 0; i < CHUNK; i++) begin
      o_cnt = o_cnt + CC_W'(i_bits[i]);
    end
  end

endmodule

// File: rtl/popcount_stream.sv
// -----------------------------------------------------------------------------
// popcount_stream
// Multi-cycle population counter with valid/ready handshakes on both sides.
// One WIDTH-bit word is accepted in IDLE and counted CHUNK bits per clock in
// BUSY. In per-word mode (mode=0) the word's count is presented in DONE; in
// accumulate mode (mode=1) counts are summed, saturating at 2^ACC_W-1, and
// the total is presented only after the word flagged in_last.
// Ports:
//   clk        : clock, rising edge
//   reset      : synchronous, active-high
//   in_valid   : in_data/in_last/mode valid
//   in_ready   : block can accept a word (IDLE and not in reset)
//   in_data    : word to count
//   in_last    : final word of an accumulate packet
//   mode       : 0 = per-word count, 1 = accumulate
//   out_valid  : out_count/out_sat valid (DONE)
//   out_ready  : consumer accepts the result
//   out_count  : count result
//   out_sat    : accumulated total was clipped
// -----------------------------------------------------------------------------
module popcount_stream
  import popcount_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_count,
  output logic             out_sat
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int CNT_W  = cnt_w(WIDTH);
  localparam int CC_W   = clog2(CHUNK + 1);
  localparam int K_W    = (NCHUNK > 1) ? clog2(NCHUNK) : 1;

  state_t             r_state;
  state_t             w_state_next;

  logic [WIDTH-1:0]   r_word;
  logic               r_mode;
  logic               r_last;
  logic [CNT_W-1:0]   r_wc;
  logic [K_W-1:0]     r_k;
  logic [ACC_W-1:0]   r_acc;
  logic               r_sat;
  logic [ACC_W-1:0]   r_out_count;
  logic               r_out_sat;

  logic [CC_W-1:0]    w_chunk_cnt;
  logic [CNT_W-1:0]   w_wc_next;
  logic [ACC_W:0]     w_sum;
  logic               w_ovf;
  logic [ACC_W-1:0]   w_sum_sat;
  logic               w_last_beat;
  logic               w_accept;

  // The word register is shifted down one chunk per beat, so the slice being
  // counted is always the low CHUNK bits.
  popcount_chunk #(.CHUNK(CHUNK)) u_chunk (
    .i_bits (r_word[CHUNK-1:0]),
    .o_cnt  (w_chunk_cnt)
  );

  assign w_wc_next   = r_wc + CNT_W'(w_chunk_cnt);
  assign w_last_beat = (r_k == K_W'(NCHUNK - 1));
  assign w_accept    = in_valid && in_ready;

  // One extra bit of headroom exposes overflow as the carry-out.
  assign w_sum     = {1'b0, r_acc} + (ACC_W + 1)'(w_wc_next);
  assign w_ovf     = w_sum[ACC_W];
  assign w_sum_sat = w_ovf ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = !reset;
        if (w_accept) w_state_next = BUSY;
      end
      BUSY: begin
        // Mid-packet accumulate words return to IDLE without a result.
        if (w_last_beat) w_state_next = (!r_mode || r_last) ? DONE : IDLE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Captured word and its attributes; not reset, only meaningful once accepted.
  always_ff @(posedge clk) begin
    if (r_state == IDLE && w_accept) begin
      r_word <= in_data;
      r_mode <= mode;
      r_last <= in_last;
    end else if (r_state == BUSY) begin
      r_word <= r_word >> CHUNK;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wc        <= '0;
      r_k         <= '0;
      r_acc       <= '0;
      r_sat       <= 1'b0;
      r_out_count <= '0;
      r_out_sat   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_wc <= '0;
            r_k  <= '0;
          end
        end
        BUSY: begin
          r_wc <= w_wc_next;
          r_k  <= r_k + K_W'(1);
          if (w_last_beat) begin
            if (!r_mode) begin
              // Per-word result leaves any open packet untouched.
              r_out_count <= ACC_W'(w_wc_next);
              r_out_sat   <= 1'b0;
            end else if (!r_last) begin
              r_acc <= w_sum_sat;
              r_sat <= r_sat | w_ovf;
            end else begin
              r_out_count <= w_sum_sat;
              r_out_sat   <= r_sat | w_ovf;
              r_acc       <= '0;
              r_sat       <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign out_count = r_out_count;
  assign out_sat   = r_out_sat;

endmodule
